// File: rtl/accumulator_pkg.sv
// Shared definitions for the phase accumulator and its phase consumers.
package accumulator_pkg;

  localparam int unsigned PHASE_W = 8;

  typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/accumulator.sv
// NCO phase accumulator: adds phinc to the phase register every clock, modulo 2^WIDTH.
// wrap is a registered carry-out, so it lines up with the cycle phase shows the wrapped value.
module accumulator
  import accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = PHASE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clrn,
  input  logic [WIDTH-1:0] phinc,
  output logic [WIDTH-1:0] phase,
  output logic             wrap
);

  logic [WIDTH-1:0] phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   sum;

  // One extra bit so the carry out of the modulo add becomes the wrap strobe.
  assign sum = {1'b0, phase_q} + {1'b0, phinc};

  always_comb begin
    phase_d = sum[WIDTH-1:0];
    wrap_d  = sum[WIDTH];
    if (!clrn) begin
      phase_d = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  assign phase = phase_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_accumulator.sv
// Directed self-checking bench for the phase accumulator (WIDTH=8).
module tb_accumulator;

  logic       clk;
  logic       rst;
  logic       clrn;
  logic [7:0] phinc;
  logic [7:0] phase;
  logic       wrap;

  int total;
  int bad;
  int wraps;

  accumulator #(
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .clrn (clrn),
    .phinc(phinc),
    .phase(phase),
    .wrap (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] p, input logic w);
    check({tag, " phase"}, {24'd0, phase}, {24'd0, p});
    check({tag, " wrap"}, {31'd0, wrap}, {31'd0, w});
  endtask

  // One clrn-low edge, leaving clrn high afterwards.
  task automatic clear_one();
    clrn = 1'b0;
    tick();
    expect_out("clear", 8'd0, 1'b0);
    clrn = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wraps = 0;
    rst   = 1'b0;
    clrn  = 1'b0;
    phinc = 8'd2;

    // Reset asserted between edges; rst and clrn both active.
    #2 rst = 1'b1;
    #1 expect_out("async_rst_init", 8'd0, 1'b0);
    tick();
    expect_out("rst_hold1", 8'd0, 1'b0);
    tick();
    expect_out("rst_hold2", 8'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("clrn_hold", 8'd0, 1'b0);
    end

    // Ramp by 2 for 640 edges: phase = 2k mod 256, wrap on each return to 0.
    clrn = 1'b1;
    for (int k = 1; k <= 640; k++) begin
      tick();
      expect_out("ramp", 8'((2 * k) % 256), ((2 * k) % 256) == 0);
      if (wrap === 1'b1) wraps++;
    end
    check("ramp_wrap_count", wraps, 5);

    // Mid-run clear, two identical passes.
    for (int pass = 0; pass < 2; pass++) begin
      clear_one();
      for (int k = 1; k <= 70; k++) begin
        tick();
        expect_out("pass_ramp", 8'(2 * k), 1'b0);
      end
      clrn = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        expect_out("mid_clear", 8'd0, 1'b0);
      end
      clrn = 1'b1;
      tick();
      expect_out("restart1", 8'd2, 1'b0);
      tick();
      expect_out("restart2", 8'd4, 1'b0);
    end

    // Async reset while phase=100.
    clear_one();
    for (int k = 1; k <= 50; k++) tick();
    expect_out("pre_rst_100", 8'd100, 1'b0);
    #3 rst = 1'b1;
    #1 expect_out("async_rst_mid", 8'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    expect_out("post_rst_first", 8'd2, 1'b0);

    // phinc=128 alternates, then async reset while wrap is high.
    clear_one();
    phinc = 8'd128;
    tick();
    expect_out("half_a", 8'd128, 1'b0);
    tick();
    expect_out("half_b", 8'd0, 1'b1);
    tick();
    expect_out("half_c", 8'd128, 1'b0);
    tick();
    expect_out("half_d", 8'd0, 1'b1);
    #2 rst = 1'b1;
    #1 expect_out("async_rst_wrap", 8'd0, 1'b0);
    tick();
    rst = 1'b0;

    // phinc=255 from 0 counts down.
    clear_one();
    phinc = 8'd255;
    tick();
    expect_out("dec_255", 8'd255, 1'b0);
    tick();
    expect_out("dec_254", 8'd254, 1'b1);
    tick();
    expect_out("dec_253", 8'd253, 1'b1);

    // Increment change on the fly, then frozen with phinc=0.
    clear_one();
    phinc = 8'd2;
    for (int k = 1; k <= 5; k++) tick();
    expect_out("at_10", 8'd10, 1'b0);
    phinc = 8'd5;
    tick();
    expect_out("step5_a", 8'd15, 1'b0);
    tick();
    expect_out("step5_b", 8'd20, 1'b0);
    phinc = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("frozen", 8'd20, 1'b0);
    end

    // Exact landing on 0 counts as overflow; pulse lasts one cycle; clear kills wrap.
    clear_one();
    phinc = 8'd254;
    tick();
    expect_out("land_254", 8'd254, 1'b0);
    phinc = 8'd2;
    tick();
    expect_out("land_0", 8'd0, 1'b1);
    phinc = 8'd0;
    tick();
    expect_out("land_hold", 8'd0, 1'b0);
    phinc = 8'd128;
    tick();
    tick();
    expect_out("pre_clear_wrap", 8'd0, 1'b1);
    clear_one();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
